// File: rtl/fsqrt_table_loader.sv
// Loads the fsqrt coefficient table from a big-endian byte stream into the coefficient RAM
// write port, then checks a trailing mod-256 checksum byte.
`timescale 1ns/1ps

module fsqrt_table_loader #(
    parameter int ENTRIES = 1024,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 36,
    parameter int NBYTES  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum,
    output logic [1:0]        state_dbg
);

    // Handshake: a byte transfers on a rising edge where in_valid & in_ready are both high.
    // in_ready depends only on the FSM state, never on in_valid.

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Byte 0 carries only the top TOP_W bits of a word; the rest of it must be zero.
    localparam int TOP_W  = DATA_W - 8 * (NBYTES - 1);
    localparam int ASM_W  = DATA_W - 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ENTRIES - 1);

    logic [1:0]        state_q,    state_d;
    logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ASM_W-1:0]  asm_q,      asm_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              err_q,      err_d;
    logic [7:0]        csum_q,     csum_d;

    logic accept;
    logic ready;

    assign ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign accept = in_valid && ready;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        csum_d     = csum_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                    csum_d     = '0;
                    err_d      = 1'b0;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    csum_d = csum_q + in_data;
                    if (byte_idx_q == '0) begin
                        asm_d = {{(ASM_W - TOP_W){1'b0}}, in_data[TOP_W-1:0]};
                        if (in_data[7:TOP_W] != '0) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        asm_d = {asm_q[ASM_W-9:0], in_data};
                    end

                    // The write is issued the cycle after the last byte, so it overlaps
                    // receipt of the next word's first byte.
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d = '0;
                        we_d       = 1'b1;
                        waddr_d    = word_idx_q;
                        wdata_d    = {asm_q, in_data};
                        word_idx_d = word_idx_q + 1'b1;
                        if (word_idx_q == LAST_WORD) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
            end

            S_CHECK: begin
                if (accept) begin
                    err_d   = err_q | (in_data != csum_q);
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            csum_q     <= csum_d;
        end
    end

    assign in_ready  = ready;
    assign busy      = ready;
    assign done      = (state_q == S_DONE);
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign err       = err_q;
    assign checksum  = csum_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fsqrt_table_loader.sv
// Directed bench for fsqrt_table_loader: a table of full-load scenarios plus hand-written
// reset-mid-load and reset-state sequences.
`timescale 1ns/1ps

module tb_fsqrt_table_loader;

  localparam int ENTRIES = 1024;
  localparam int NBYTES = 5;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [35:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  checksum;
  logic [1:0]  state_dbg;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int timeouts = 0;

  fsqrt_table_loader #(
    .ENTRIES(ENTRIES),
    .ADDR_W (10),
    .DATA_W (36),
    .NBYTES (NBYTES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- write monitor (RAM model) ----------------
  logic [35:0] ram_m [0:ENTRIES-1];
  int          wr_cnt = 0;
  int          order_err = 0;
  logic [9:0]  mon_idx;

  always @(negedge clk) begin
    if (rst || (start && !busy)) begin
      for (int i = 0; i < ENTRIES; i++) ram_m[i] = '1;
      wr_cnt = 0;
      order_err = 0;
      mon_idx = '0;
    end else if (we) begin
      if (waddr !== mon_idx) order_err++;
      ram_m[waddr] = wdata;
      wr_cnt++;
      mon_idx++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] word_byte(input int w, input int k, input int bad_word,
                                           input logic [7:0] bad_val);
    logic [31:0] lo;
    lo = 32'(w) * 32'h01010101;
    if (k == 0) return (w == bad_word) ? bad_val : 8'h00;
    return lo[31 - 8 * (k - 1) -: 8];
  endfunction

  function automatic logic [35:0] exp_word(input int w, input int bad_word,
                                           input logic [7:0] bad_val);
    logic [31:0] lo;
    logic [3:0]  top;
    lo  = 32'(w) * 32'h01010101;
    top = (w == bad_word) ? bad_val[3:0] : 4'h0;
    return {top, lo};
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers (called just after a rising edge) ----------------
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    int   t;
    ok = 1'b0;
    t = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) timeouts++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         bad_word;
    logic [7:0] bad_val;
    logic [7:0] csum_off;
    int         gap_pct;
    bit         mid_starts;
    bit         exp_err;
  } scen_t;

  task automatic run_load(input scen_t sc);
    logic [7:0] sum;
    logic [7:0] b;
    int         early_done;
    int         mism;
    sum = 8'h00;
    early_done = 0;
    mism = 0;
    timeouts = 0;

    pulse_start();
    @(negedge clk);
    check({sc.name, " start_busy"}, busy, 1'b1);
    check({sc.name, " start_done_clr"}, done, 1'b0);
    check({sc.name, " start_err_clr"}, err, 1'b0);
    check({sc.name, " start_csum_clr"}, checksum, 8'h00);
    check({sc.name, " start_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int w = 0; w < ENTRIES; w++) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (sc.gap_pct > 0 && $urandom_range(0, 99) < sc.gap_pct) begin
          int n;
          n = $urandom_range(1, 3);
          if (sc.mid_starts && $urandom_range(0, 9) == 0) start = 1'b1;
          repeat (n) begin
            @(negedge clk);
            if (done) early_done++;
            @(posedge clk);
            #1;
            start = 1'b0;
          end
        end
        b = word_byte(w, k, sc.bad_word, sc.bad_val);
        send_byte(b);
        sum = sum + b;
      end
    end

    // Last data byte just transferred: the final write lands in the first CHECK cycle.
    if (sc.mid_starts) start = 1'b1;
    @(negedge clk);
    check({sc.name, " final_we"}, we, 1'b1);
    check({sc.name, " final_waddr"}, waddr, 10'd1023);
    check({sc.name, " final_wdata"}, wdata, exp_word(ENTRIES - 1, sc.bad_word, sc.bad_val));
    check({sc.name, " check_state"}, state_dbg, 2'd2);
    check({sc.name, " no_done_before_csum"}, done, 1'b0);
    check({sc.name, " running_csum"}, checksum, sum);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check({sc.name, " we_one_cycle"}, we, 1'b0);
    check({sc.name, " waddr_hold"}, waddr, 10'd1023);
    @(posedge clk);
    #1;

    send_byte(sum + sc.csum_off);
    @(negedge clk);
    check({sc.name, " done"}, done, 1'b1);
    check({sc.name, " busy_end"}, busy, 1'b0);
    check({sc.name, " ready_end"}, in_ready, 1'b0);
    check({sc.name, " err"}, err, sc.exp_err);
    check({sc.name, " done_state"}, state_dbg, 2'd3);

    // Bytes offered after the load must be refused.
    @(posedge clk);
    #1;
    in_data = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({sc.name, " write_count"}, wr_cnt, ENTRIES);
    check({sc.name, " write_order"}, order_err, 0);
    check({sc.name, " done_held"}, done, 1'b1);
    check({sc.name, " csum_final"}, checksum, sum);
    check({sc.name, " early_done"}, early_done, 0);
    check({sc.name, " byte_timeouts"}, timeouts, 0);
    for (int i = 0; i < ENTRIES; i++)
      if (ram_m[i] !== exp_word(i, sc.bad_word, sc.bad_val)) mism++;
    check({sc.name, " ram_image"}, mism, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    scen_t vec [6];
    vec[0] = '{name: "clean",      bad_word: -1,   bad_val: 8'h00, csum_off: 8'd0,
               gap_pct: 0,  mid_starts: 1'b0, exp_err: 1'b0};
    vec[1] = '{name: "bad_csum",   bad_word: -1,   bad_val: 8'h00, csum_off: 8'd1,
               gap_pct: 0,  mid_starts: 1'b0, exp_err: 1'b1};
    vec[2] = '{name: "restart_ok", bad_word: -1,   bad_val: 8'h00, csum_off: 8'd0,
               gap_pct: 0,  mid_starts: 1'b0, exp_err: 1'b0};
    vec[3] = '{name: "nibble_w7",  bad_word: 7,    bad_val: 8'hF3, csum_off: 8'd0,
               gap_pct: 0,  mid_starts: 1'b0, exp_err: 1'b1};
    vec[4] = '{name: "gaps",       bad_word: -1,   bad_val: 8'h00, csum_off: 8'd0,
               gap_pct: 30, mid_starts: 1'b1, exp_err: 1'b0};
    vec[5] = '{name: "nibble_last", bad_word: 1023, bad_val: 8'h2A, csum_off: 8'd0,
               gap_pct: 0,  mid_starts: 1'b0, exp_err: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 10'd0);
    check("rst_wdata", wdata, 36'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_checksum", checksum, 8'h00);
    rst = 1'b0;
    // Bytes offered in IDLE without a start are not taken.
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    check("idle_state", state_dbg, 2'd0);
    check("idle_not_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    for (int s = 0; s < 6; s++) run_load(vec[s]);

    // Reset in the middle of a load, right while a write pulse is out.
    pulse_start();
    for (int i = 0; i < 2000; i++) send_byte(word_byte(i / NBYTES, i % NBYTES, -1, 8'h00));
    check("pre_rst_we", we, 1'b1);
    check("pre_rst_waddr", waddr, 10'd399);
    rst = 1'b1;
    #1;
    check("mid_rst_we", we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_waddr", waddr, 10'd0);
    check("mid_rst_checksum", checksum, 8'h00);
    check("mid_rst_state", state_dbg, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_load('{name: "after_rst", bad_word: -1, bad_val: 8'h00, csum_off: 8'd0,
               gap_pct: 0, mid_starts: 1'b0, exp_err: 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
